uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler.sv | 135 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter feeding a single UART transmitter: one byte per frame,
// start bit, DATA_WIDTH data bits LSB first, one stop bit, OVERSAMPLE ticks per bit.
//
// state | meaning
// IDLE  | line high, waiting for any requester; grant happens in this cycle
// START | start bit (tx=0)
// DATA  | data bits, LSB first
// STOP  | stop bit (tx=1)
module uart_tx_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          sample_tick,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          tx
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state;
    logic [ID_W-1:0]       pointer;
    logic [ID_W-1:0]       grant_idx;
    logic                  grant_found;
    logic [DATA_WIDTH-1:0] grant_data;
    logic [TICK_W-1:0]     tick_cnt;
    logic [BIT_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic                  grant;
    logic                  bit_end;

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        logic [ID_W:0] sum;
        grant_found = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, pointer} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ))
                sum = sum - (ID_W+1)'(NUM_REQ);
            if (!grant_found && req_valid[sum[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (ID_W'(i) == grant_idx)
                grant_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Ready is a same-cycle handshake with valid, so it is decoded, not registered.
    assign grant = (state == IDLE) && grant_found && !reset;

    always_comb begin
        req_ready = '0;
        if (grant)
            req_ready[grant_idx] = 1'b1;
    end

    assign bit_end   = sample_tick && (tick_cnt == TICK_W'(OVERSAMPLE - 1));
    assign shift_nxt = shift_reg >> 1;
    assign busy      = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            grant_id  <= '0;
            pointer   <= '0;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            if (state != IDLE && sample_tick)
                tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (grant) begin
                        shift_reg <= grant_data;
                        grant_id  <= grant_idx;
                        pointer   <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        tick_cnt  <= '0;
                        bit_idx   <= '0;
                        tx        <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_idx <= '0;
                        tx      <= shift_reg[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == BIT_W'(DATA_WIDTH - 1)) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= shift_nxt;
                            tx        <= shift_nxt[0];
                        end
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (bit_end)
                        state <= IDLE;
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: frame bit levels, round-robin order,
// reset abort, data stability after grant and tick stalls.
module tb_uart_tx_scheduler;
    logic        clock = 1'b0;
    logic        reset;
    logic        sample_tick;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [1:0]  grant_id;
    logic        busy;
    logic        tx;

    int checks = 0;
    int failures = 0;

    uart_tx_scheduler #(.NUM_REQ(4), .DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .sample_tick(sample_tick),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .grant_id   (grant_id),
        .busy       (busy),
        .tx         (tx)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Entered in IDLE with req_valid/req_data already set and sample_tick high.
    // Inputs switch to valid_after/data_after right after the grant edge.
    task automatic run_frame(input logic [7:0] exp_byte, input logic [1:0] exp_gid,
                             input logic [3:0] valid_after, input logic [31:0] data_after);
        logic [9:0] bits;
        bits = {1'b1, exp_byte, 1'b0};
        #1;
        chk("grant_ready", 32'(req_ready), 32'(4'b0001 << exp_gid));
        step();
        req_valid = valid_after;
        req_data  = data_after;
        #1;
        chk("ready_after_grant", 32'(req_ready), 32'h0);
        chk("grant_id", 32'(grant_id), 32'(exp_gid));
        chk("busy_start", 32'(busy), 32'h1);
        for (int i = 0; i < 160; i++) begin
            step();
            if (i % 16 == 7)
                chk($sformatf("tx_bit%0d", i / 16), 32'(tx), 32'(bits[i / 16]));
            if (i == 158)
                chk("busy_last_tick", 32'(busy), 32'h1);
        end
        chk("busy_end", 32'(busy), 32'h0);
        chk("tx_idle", 32'(tx), 32'h1);
    endtask

    initial begin
        reset       = 1'b1;
        sample_tick = 1'b1;
        req_valid   = 4'b0000;
        req_data    = 32'h0;
        do_reset();
        chk("rst_tx", 32'(tx), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_gid", 32'(grant_id), 32'h0);

        // Single byte A5; tick in grant cycle and IDLE ticks must be ignored.
        req_valid = 4'b0001;
        req_data  = 32'h0000_00A5;
        run_frame(8'hA5, 2'd0, 4'b0000, 32'h0000_00A5);

        // All four valid: round robin 0,1,2,3,0, back-to-back.
        do_reset();
        req_valid = 4'b1111;
        req_data  = 32'h4433_2211;
        run_frame(8'h11, 2'd0, 4'b1111, 32'h4433_2211);
        run_frame(8'h22, 2'd1, 4'b1111, 32'h4433_2211);
        run_frame(8'h33, 2'd2, 4'b1111, 32'h4433_2211);
        run_frame(8'h44, 2'd3, 4'b1111, 32'h4433_2211);
        run_frame(8'h11, 2'd0, 4'b0000, 32'h4433_2211);

        // Pointer reaches 2 with only 0,1 valid: wraps to 0, then 1.
        do_reset();
        req_valid = 4'b0011;
        req_data  = 32'h0000_C33C;
        run_frame(8'h3C, 2'd0, 4'b0011, 32'h0000_C33C);
        run_frame(8'hC3, 2'd1, 4'b0011, 32'h0000_C33C);
        run_frame(8'h3C, 2'd0, 4'b0011, 32'h0000_C33C);
        run_frame(8'hC3, 2'd1, 4'b0000, 32'h0000_C33C);

        // Reset 40 ticks into a frame aborts it; no grant while reset is high.
        do_reset();
        req_valid = 4'b0001;
        req_data  = 32'h0000_5A00;
        step();
        req_valid = 4'b0000;
        repeat (40) step();
        chk("pre_abort_busy", 32'(busy), 32'h1);
        reset     = 1'b1;
        req_valid = 4'b0010;
        step();
        chk("abort_tx", 32'(tx), 32'h1);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("no_grant_in_reset", 32'(req_ready), 32'h0);
        step();
        reset = 1'b0;
        run_frame(8'h5A, 2'd1, 4'b0000, 32'h0000_5A00);

        // Data changed to FF after grant of 00 must not leak into the frame.
        do_reset();
        req_valid = 4'b0001;
        req_data  = 32'h0000_0000;
        run_frame(8'h00, 2'd0, 4'b0000, 32'h0000_00FF);

        // Tick stall mid-DATA (bit1 of 03 is 1, bit2 is 0).
        do_reset();
        req_valid = 4'b0001;
        req_data  = 32'h0000_0003;
        step();
        req_valid = 4'b0000;
        repeat (40) step();
        sample_tick = 1'b0;
        repeat (100) step();
        chk("stall_tx", 32'(tx), 32'h1);
        chk("stall_busy", 32'(busy), 32'h1);
        sample_tick = 1'b1;
        repeat (7) step();
        chk("resume_bit1", 32'(tx), 32'h1);
        step();
        chk("resume_bit2", 32'(tx), 32'h0);
        repeat (111) step();
        chk("resume_busy_last", 32'(busy), 32'h1);
        step();
        chk("resume_busy_end", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
